// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, decoder handshake and
// branch redirect. master = fetch unit, slave = memory/decoder/branch side.
interface instr_fetch_unit_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_hi;
  logic [15:0] instr_lo;
  logic        instr_is_long;
  logic [15:0] instr_pc;
  logic        branch_en;
  logic [15:0] branch_addr;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output instr_valid, instr_hi, instr_lo, instr_is_long, instr_pc,
    input  instr_ready,
    input  branch_en, branch_addr
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  instr_valid, instr_hi, instr_lo, instr_is_long, instr_pc,
    output instr_ready,
    output branch_en, branch_addr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads one or two 16-bit words per instruction
// (group 5 = two words) and holds the result until the decoder accepts it.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic clk,
  input  logic reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {FETCH_HI, FETCH_LO, HOLD} state_t;

  localparam logic [5:0] LONG_OP = 6'b111000;

  state_t      state;
  logic [15:0] pc;

  // Request is a pure decode of state; gating with reset keeps the bus quiet
  // for the whole reset window, including the first reset cycle.
  assign bus.mem_req  = ~reset & (state != HOLD);
  assign bus.mem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= FETCH_HI;
      pc                <= RESET_PC;
      bus.instr_valid   <= 1'b0;
      bus.instr_hi      <= 16'h0000;
      bus.instr_lo      <= 16'h0000;
      bus.instr_is_long <= 1'b0;
      bus.instr_pc      <= 16'h0000;
    end else if (bus.branch_en) begin
      // Redirect wins over any ack this cycle; a held instruction is
      // considered consumed by the decoder if it was ready.
      state           <= FETCH_HI;
      pc              <= bus.branch_addr;
      bus.instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH_HI: begin
          if (bus.mem_ack) begin
            bus.instr_hi <= bus.mem_rdata;
            bus.instr_pc <= pc;
            pc           <= pc + 16'd1;
            if (bus.mem_rdata[15:10] == LONG_OP) begin
              bus.instr_is_long <= 1'b1;
              state             <= FETCH_LO;
            end else begin
              bus.instr_is_long <= 1'b0;
              bus.instr_lo      <= 16'h0000;
              bus.instr_valid   <= 1'b1;
              state             <= HOLD;
            end
          end
        end
        FETCH_LO: begin
          if (bus.mem_ack) begin
            bus.instr_lo    <= bus.mem_rdata;
            pc              <= pc + 16'd1;
            bus.instr_valid <= 1'b1;
            state           <= HOLD;
          end
        end
        HOLD: begin
          if (bus.instr_valid && bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            state           <= FETCH_HI;
          end
        end
        default: state <= FETCH_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a scoreboard queue of expected
// instructions, drained by a monitor on every cycle the DUT presents one.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        is_long;
    logic [15:0] pc;
  } instr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] mem [65536];
  instr_t exp_q[$];
  int errors = 0;
  int checks = 0;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic instr_t mk(logic [15:0] hi, logic [15:0] lo, logic l, logic [15:0] pc);
    instr_t t;
    t.hi = hi; t.lo = lo; t.is_long = l; t.pc = pc;
    return t;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  // Monitor: samples just after the stimulus has set instr_ready for the
  // coming edge, so a pop happens exactly when the DUT sees the handshake.
  always @(negedge clk) begin
    #2;
    if (!reset && bus.instr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got hi=%h pc=%h expected none", bus.instr_hi, bus.instr_pc);
      end else begin
        chk("instr", {15'd0, bus.instr_hi, bus.instr_lo, bus.instr_is_long, bus.instr_pc}, {15'd0, exp_q[0]});
        if (bus.instr_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0]       = 16'h1234;
    mem[1]       = 16'h1111;
    mem[2]       = 16'h2222;
    mem[3]       = 16'h3333;
    mem[4]       = 16'hE0A5;
    mem[5]       = 16'h7F01;
    mem[6]       = 16'h4444;
    mem[7]       = 16'hE0F0;
    mem[8]       = 16'hBEEF;
    mem[9]       = 16'hE001;
    mem[10]      = 16'h6666;
    mem[16'h0100] = 16'h5555;
    mem[16'hFFFF] = 16'hE123;

    bus.mem_ack     = 1'b1;
    bus.instr_ready = 1'b1;
    bus.branch_en   = 1'b0;
    bus.branch_addr = 16'h0000;

    // Reset with ack high: nothing may be requested or captured.
    cyc();
    chk("rst_req", bus.mem_req, 0);
    chk("rst_outs", {bus.instr_valid, bus.instr_hi, bus.instr_lo, bus.instr_is_long, bus.instr_pc}, 0);
    cyc();
    chk("rst_req2", bus.mem_req, 0);

    exp_q.push_back(mk(16'h1234, 16'h0000, 1'b0, 16'h0000));
    exp_q.push_back(mk(16'h1111, 16'h0000, 1'b0, 16'h0001));
    exp_q.push_back(mk(16'h2222, 16'h0000, 1'b0, 16'h0002));
    exp_q.push_back(mk(16'h3333, 16'h0000, 1'b0, 16'h0003));
    exp_q.push_back(mk(16'hE0A5, 16'h7F01, 1'b1, 16'h0004));
    exp_q.push_back(mk(16'h4444, 16'h0000, 1'b0, 16'h0006));
    exp_q.push_back(mk(16'hE0F0, 16'hBEEF, 1'b1, 16'h0007));
    exp_q.push_back(mk(16'h5555, 16'h0000, 1'b0, 16'h0100));
    exp_q.push_back(mk(16'hE123, 16'h1234, 1'b1, 16'hFFFF));
    reset = 1'b0;
    #1;
    chk("first_req", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0000});
    chk("first_novalid", bus.instr_valid, 0);

    cyc();                                   // 1234 held
    chk("hold_noreq", bus.mem_req, 0);
    cyc();
    chk("next_addr1", {bus.mem_req, bus.mem_addr, bus.instr_valid}, {1'b1, 16'h0001, 1'b0});
    repeat (6) cyc();                        // 1111, 2222, 3333 stream through
    chk("long_hi_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0004});
    cyc();
    chk("long_lo_addr", {bus.mem_req, bus.mem_addr, bus.instr_valid}, {1'b1, 16'h0005, 1'b0});
    cyc();                                   // E0A5/7F01 held
    cyc();
    chk("after_long_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0006});

    // Decoder stalls 5 cycles on the short instruction at 6.
    cyc();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_hold", {bus.mem_req, bus.instr_valid}, {1'b0, 1'b1});
    end
    bus.instr_ready = 1'b1;
    cyc();
    chk("post_stall_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0007});

    // Memory stalls 3 cycles on the second word of the long at 7.
    cyc();
    chk("lo_wait_addr", {bus.mem_req, bus.mem_addr, bus.instr_valid}, {1'b1, 16'h0008, 1'b0});
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("lo_wait", {bus.mem_req, bus.mem_addr, bus.instr_valid}, {1'b1, 16'h0008, 1'b0});
    end
    bus.mem_ack = 1'b1;
    cyc();                                   // E0F0/BEEF held
    cyc();
    chk("addr9", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0009});

    // Branch during FETCH_LO with ack high: second word discarded.
    cyc();
    chk("addr10", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h000A});
    bus.branch_en   = 1'b1;
    bus.branch_addr = 16'h0100;
    cyc();
    bus.branch_en = 1'b0;
    chk("branch_addr", {bus.mem_req, bus.mem_addr, bus.instr_valid}, {1'b1, 16'h0100, 1'b0});

    // Branch in the same cycle as a handshake: 5555 consumed, redirect taken.
    cyc();
    bus.branch_en   = 1'b1;
    bus.branch_addr = 16'hFFFF;
    cyc();
    bus.branch_en = 1'b0;
    chk("branch_hs_addr", {bus.mem_req, bus.mem_addr, bus.instr_valid}, {1'b1, 16'hFFFF, 1'b0});
    cyc();
    chk("wrap_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0000});
    cyc();                                   // E123/1234 at FFFF held
    bus.branch_en   = 1'b1;
    bus.branch_addr = 16'hFFFF;
    cyc();
    bus.branch_en = 1'b0;
    chk("refetch_ffff", {bus.mem_req, bus.mem_addr}, {1'b1, 16'hFFFF});

    // Reset in FETCH_LO with ack high: everything back to reset values.
    cyc();
    chk("wrap_addr2", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0000});
    reset = 1'b1;
    #1;
    chk("rst_midlo_req", bus.mem_req, 0);
    cyc();
    chk("rst_midlo_outs", {bus.mem_req, bus.instr_valid, bus.instr_hi, bus.instr_lo, bus.instr_is_long, bus.instr_pc}, 0);
    exp_q.push_back(mk(16'h1234, 16'h0000, 1'b0, 16'h0000));
    reset = 1'b0;
    #1;
    chk("restart_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h0000});
    cyc();
    chk("restart_hold", bus.mem_req, 0);
    bus.mem_ack = 1'b0;
    repeat (3) cyc();
    chk("noack_stable", {bus.mem_req, bus.mem_addr, bus.instr_valid}, {1'b1, 16'h0001, 1'b0});
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, fetch address loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_req  output  1  instruction-memory read request.
REQ-005 mem_addr  output  16  word address of current request.
REQ-006 mem_ack  input  1  read data valid on mem_rdata this cycle; ignored when mem_req=0.
REQ-007 mem_rdata  input  16  instruction word returned.
REQ-008 instr_valid  output  1  instr_hi/instr_lo/instr_is_long/instr_pc hold a complete instruction.
REQ-009 instr_ready  input  1  decoder accepts the instruction this cycle.
REQ-010 instr_hi  output  16  first instruction word, drives the group decoders.
REQ-011 instr_lo  output  16  second word (iiii iiii jjjj jjjj) of a group-5 instruction; 16'h0000 for single-word instructions.
REQ-012 instr_is_long  output  1  instruction is two words (group 5).
REQ-013 instr_pc  output  16  address of instr_hi.
REQ-014 branch_en  input  1  redirect fetch.
REQ-015 branch_addr  input  16  redirect target.

Function
REQ-016 States: FETCH_HI, FETCH_LO, HOLD; internal 16-bit pc.
REQ-017 FETCH_HI: mem_req=1, mem_addr=pc; on mem_ack capture mem_rdata into instr_hi, set instr_pc=pc, pc<=pc+1.
REQ-018 Long detection on the captured word: instr_is_long=1 iff mem_rdata[15:10]==6'b111000; otherwise 0. Unknown-group words are issued as single-word instructions.
REQ-019 FETCH_HI + ack + long -> FETCH_LO; FETCH_HI + ack + short -> HOLD with instr_lo<=16'h0000; no ack -> stay, mem_addr stable.
REQ-020 FETCH_LO: mem_req=1, mem_addr=pc; on mem_ack capture instr_lo, pc<=pc+1, -> HOLD; no ack -> stay.
REQ-021 HOLD: mem_req=0, instr_valid=1; instr outputs stable while instr_ready=0; instr_valid&instr_ready -> FETCH_HI next cycle.
REQ-022 instr_valid=1 only in HOLD; registered output, never combinational from mem_ack.
REQ-023 Latency with mem_ack tied high: short instr valid 1 cycle after FETCH_HI; long instr valid 2 cycles after FETCH_HI; minimum issue rate one short instr per 2 cycles.
REQ-024 pc arithmetic modulo 2^16: 16'hFFFF+1=16'h0000; a long instr at 16'hFFFF fetches its second word from 16'h0000.
REQ-025 branch_en=1 in any state: pc<=branch_addr, state<=FETCH_HI, instr_valid=0 next cycle; any mem_ack that cycle is discarded, pc not incremented by it.
REQ-026 branch_en with instr_valid&instr_ready same cycle: handshake completes (instruction consumed), redirect still applies.
REQ-027 Abandoning a request (mem_req dropping on branch/reset) is legal for the memory; no acknowledgement owed.

Reset
REQ-028 reset=1 at a clock edge, in any state: state<=FETCH_HI, pc<=RESET_PC, instr_valid<=0, instr_hi<=0, instr_lo<=0, instr_is_long<=0, instr_pc<=0.
REQ-029 While reset=1: mem_req=0; first request (mem_addr=RESET_PC) in the cycle after reset deasserts.
REQ-030 reset dominates branch_en and mem_ack in the same cycle; in-flight data discarded.

Verification
REQ-031 Reset, mem_ack=1, mem[0]=16'h1234, instr_ready=1 -> instr_valid 1 cycle after first request, instr_hi=16'h1234, instr_lo=0, instr_is_long=0, instr_pc=0; next mem_addr=1.
REQ-032 mem[4]=16'hE0A5, mem[5]=16'h7F01, pc=4 -> mem_addr 4 then 5, then instr_hi=16'hE0A5, instr_lo=16'h7F01, instr_is_long=1, instr_pc=4; next fetch at 6.
REQ-033 instr_ready=0 for 5 cycles in HOLD -> outputs stable, mem_req=0 throughout; instr_ready=1 -> FETCH_HI at pc+1 next cycle.
REQ-034 mem_ack=0 for 3 cycles during FETCH_LO -> mem_req=1, mem_addr constant, instr_valid=0 until ack.
REQ-035 branch_en=1, branch_addr=16'h0100 during FETCH_LO with mem_ack=1 -> ack discarded, next mem_addr=16'h0100, instr_valid stays 0.
REQ-036 Long instr at 16'hFFFF (mem[FFFF]=16'hE123) -> second fetch at 16'h0000, instr_pc=16'hFFFF; reset asserted mid-FETCH_LO -> all outputs at reset values, restart at RESET_PC.
